// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N byte producers.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int BUSY_TO = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   ack,
    output logic           tx_start,
    output logic [7:0]     tx_data,
    input  logic           tx_busy,
    output logic [2:0]     grant_id,
    output logic           to_err
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    ack_q;
    logic            tx_start_q;
    logic [7:0]      tx_data_q;
    logic [2:0]      grant_id_q;
    logic            to_err_q;

    logic [IW-1:0]   win_d;
    logic            hit_d;
    logic [7:0]      byte_w [N];

    for (genvar g = 0; g < N; g++) begin : g_byte
        assign byte_w[g] = req_data[8*g +: 8];
    end

    // Walk from the farthest candidate back to the nearest so the
    // highest-priority requester is the last assignment.
    always_comb begin
        win_d = '0;
        hit_d = 1'b0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_d = IW'(i);
                hit_d = 1'b1;
            end
        end
`else
        for (int k = N; k >= 1; k--) begin
            if (req[IW'((int'(grant_id_q) + k) % N)]) begin
                win_d = IW'((int'(grant_id_q) + k) % N);
                hit_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_id_q <= 3'(N - 1);
            to_err_q   <= 1'b0;
        end else begin
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!tx_busy && hit_d) begin
                        ack_q      <= N'(1) << win_d;
                        tx_data_q  <= byte_w[win_d];
                        grant_id_q <= 3'(win_d);
                        state_q    <= START;
                    end
                end
                START: begin
                    tx_start_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state_q <= WAIT_LO;
                    end else if (cnt_q == CW'(BUSY_TO)) begin
                        // Transmitter never answered: drop the byte.
                        to_err_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack      = ack_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign to_err   = to_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic
// against a timestamp-based reference of the arbitration rules.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic [2:0]     grant_id;
    logic           to_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(N), .BUSY_TO(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .to_err   (to_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus knobs
    bit   auto_req = 0;
    bit   hold     = 0;
    bit   dead_all = 0;
    int   dead_pct = 0;
    int   len_min  = 3;
    int   len_max  = 3;
    bit   ext_busy = 0;
    bit   bz       = 0;
    bit   pend     = 0;
    int   busy_rem = 0;
    logic [7:0] rd [N];

    // reference model
    bit         m_act  = 0;
    bit         m_fall = 0;
    bit         m_err  = 0;
    int         m_start = 0;
    int         m_last  = N - 1;
    logic [7:0] m_data  = 8'h00;

    logic [N-1:0] exp_ack   = '0;
    logic         exp_start = 1'b0;
    logic [7:0]   exp_data  = 8'h00;
    logic [2:0]   exp_gid   = 3'(N - 1);
    logic         exp_err   = 1'b0;

    int glog [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++)
            if (((r >> i) & 1'b1) != '0) return i;
`else
        for (int k = 1; k <= N; k++)
            if (((r >> ((last + k) % N)) & 1'b1) != '0) return (last + k) % N;
`endif
        return -1;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = rd[i];
        tx_busy = ext_busy || bz;
    endtask

    // transmitter model and request generator for the coming cycle
    task automatic drive();
        if (tx_start && !dead_all && $urandom_range(99) >= dead_pct) pend = 1;
        bz = (busy_rem > 0);
        if (bz) busy_rem--;
        if (pend) begin
            busy_rem = $urandom_range(len_max, len_min);
            pend = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (ack[i] && !hold) req[i] = 1'b0;
            if (auto_req) begin
                if (!req[i]) begin
                    if ($urandom_range(7) == 0) begin
                        req[i] = 1'b1;
                        rd[i]  = 8'($urandom);
                    end
                end else if ($urandom_range(63) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        pack();
    endtask

    // Predict outputs for cycle cyc+1 from this cycle's inputs.
    task automatic predict();
        int w;
        exp_ack   = '0;
        exp_start = m_act && !m_fall && (cyc + 1 == m_start);
        if (!m_act) begin
            if (!tx_busy && req != '0) begin
                w       = pick(req, m_last);
                exp_ack = N'(1 << w);
                m_data  = rd[w];
                m_last  = w;
                m_act   = 1;
                m_fall  = 0;
                m_start = cyc + 2;
            end
        end else if (!m_fall) begin
            if (cyc >= m_start) begin
                if (tx_busy) m_fall = 1;
                else if (cyc == m_start + TO) begin
                    m_err = 1;
                    m_act = 0;
                end
            end
        end else if (!tx_busy) begin
            m_act = 0;
        end
        exp_data = m_data;
        exp_gid  = 3'(m_last);
        exp_err  = m_err;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("ack", 32'(ack), 32'(exp_ack));
        chk("tx_start", 32'(tx_start), 32'(exp_start));
        chk("tx_data", 32'(tx_data), 32'(exp_data));
        chk("grant_id", 32'(grant_id), 32'(exp_gid));
        chk("to_err", 32'(to_err), 32'(exp_err));
        for (int i = 0; i < N; i++) if (ack[i]) glog.push_back(i);
        drive();
    endtask

    task automatic step();
        tick();
        predict();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        ext_busy = 0;
        busy_rem = 0;
        pend = 0;
        bz = 0;
        pack();
        #1;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant_id", 32'(grant_id), N - 1);
        chk("rst_to_err", 32'(to_err), 0);
        m_act = 0; m_fall = 0; m_err = 0; m_last = N - 1; m_data = 8'h00;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b1;
        drive();
        predict();
    endtask

    task automatic wait_ack(input string tag, input int lim, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ack == '0 && n < lim);
        if (ack == '0) chk({tag, "_no_ack"}, 0, 1);
    endtask

    task automatic flush();
        int n;
        tick();
        req = '0;
        pack();
        predict();
        n = 0;
        while ((m_act || tx_busy) && n < 300) begin
            step();
            n++;
        end
        if (m_act || tx_busy) chk("flush_stuck", 1, 0);
    endtask

    initial begin
        int n;
        int s;
        int exp_seq [5];
        for (int i = 0; i < N; i++) rd[i] = 8'h00;
        do_reset();
        repeat (3) step();

        // single requester, long frame
        len_min = 100; len_max = 100;
        tick();
        req = 4'b0001; rd[0] = 8'h41; pack();
        predict();
        wait_ack("t2", 5, n);
        chk("t2_ack_lat", n, 1);
        chk("t2_ack", 32'(ack), 1);
        chk("t2_data", 32'(tx_data), 32'h41);
        step();
        chk("t2_start", 32'(tx_start), 1);
        tick();
        req[0] = 1'b1; rd[0] = 8'h42; pack();
        predict();
        wait_ack("t2b", 200, n);
        chk("t2_second_ack_late", 32'(n > 100), 1);
        chk("t2b_data", 32'(tx_data), 32'h42);
        repeat (20) step();
        chk("t2_in_frame", 32'(tx_busy), 1);
        do_reset();

        // all four requesting, held
        len_min = 3; len_max = 3;
        hold = 1;
        glog.delete();
        tick();
        req = 4'b1111;
        for (int i = 0; i < N; i++) rd[i] = 8'(8'h10 + i);
        pack();
        predict();
        n = 0;
        while (glog.size() < 5 && n < 200) begin
            step();
            n++;
        end
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0};
`endif
        chk("t3_count", 32'(glog.size() >= 5), 1);
        for (int i = 0; i < 5 && i < glog.size(); i++)
            chk($sformatf("t3_grant%0d", i), glog[i], exp_seq[i]);
        hold = 0;
        flush();

        // transmitter never answers
        dead_all = 1;
        tick();
        req = 4'b0001; rd[0] = 8'h55; pack();
        predict();
        n = 0;
        while (!tx_start && n < 10) begin
            step();
            n++;
        end
        s = cyc;
        n = 0;
        while (!to_err && n < 40) begin
            step();
            n++;
        end
        chk("t4_to_lat", cyc - s, TO + 1);
        dead_all = 0;
        tick();
        req = 4'b0100; rd[2] = 8'h66; pack();
        predict();
        wait_ack("t4b", 10, n);
        chk("t4_next_ack", 32'(ack), 32'b0100);
        chk("t4_next_data", 32'(tx_data), 32'h66);
        flush();

        // external busy blocks grant
        tick();
        ext_busy = 1;
        req = 4'b0010; rd[1] = 8'h77; pack();
        predict();
        s = glog.size();
        repeat (10) step();
        chk("t5_noack", glog.size() - s, 0);
        tick();
        ext_busy = 0; pack();
        predict();
        step();
        chk("t5_ack", 32'(ack), 32'b0010);
        flush();

        // requester 2 withdraws mid-frame
        len_min = 20; len_max = 20;
        tick();
        req = 4'b0010; rd[1] = 8'h21; pack();
        predict();
        wait_ack("t6", 5, n);
        chk("t6_ack1", 32'(ack), 32'b0010);
        tick();
        req[2] = 1'b1; req[3] = 1'b1; rd[2] = 8'h22; rd[3] = 8'h23; pack();
        predict();
        n = 0;
        while (!tx_busy && n < 10) begin
            step();
            n++;
        end
        repeat (3) step();
        tick();
        req[2] = 1'b0; pack();
        predict();
        wait_ack("t6b", 60, n);
        chk("t6_ack2", 32'(ack), 32'b1000);
        chk("t6_data2", 32'(tx_data), 32'h23);
        flush();

        // random traffic
        auto_req = 1; dead_pct = 10; len_min = 1; len_max = 8;
        repeat (3000) step();
        auto_req = 0;
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
